// File: rtl/alu_fu_pipe_pkg.sv
// Shared types for the pipelined ALU functional unit: operand-select and
// operation encodings, plus a shift-op classifier.
package alu_fu_pipe_pkg;

    typedef enum logic [1:0] {
        AM_RS1,
        AM_RS2,
        AM_IMM,
        AM_PC
    } ALU_SEL_TYPE;

    typedef enum logic [3:0] {
        A_ADD,
        A_SUB,
        A_AND,
        A_OR,
        A_XOR,
        A_SLL,
        A_SRL,
        A_SRA,
        A_SLT,
        A_SLTU,
        A_MIN,
        A_MAX,
        A_MINU,
        A_MAXU
    } ALU_OP_TYPE;

    function automatic logic is_shift_op(input ALU_OP_TYPE op);
        return op inside {A_SLL, A_SRL, A_SRA};
    endfunction

endpackage

// File: rtl/alu_fu_core.sv
// Combinational operand muxes and ALU operation evaluator, XLEN-bit wide.
// With ALU_SERIAL_SHIFT_EN the muxed x operand and shift amount are exported.
module alu_fu_core
    import alu_fu_pipe_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0]         i_rs1,
    input  logic [XLEN-1:0]         i_rs2,
    input  logic [XLEN-1:0]         i_imm,
    input  logic [XLEN-1:0]         i_pc,
    input  ALU_SEL_TYPE             i_sel_x,
    input  ALU_SEL_TYPE             i_sel_y,
    input  ALU_OP_TYPE              i_op,
    output logic [XLEN-1:0]         o_result
`ifdef ALU_SERIAL_SHIFT_EN
    ,
    output logic [XLEN-1:0]         o_x,
    output logic [$clog2(XLEN)-1:0] o_shamt
`endif
);

    localparam int unsigned SW = $clog2(XLEN);

    logic [XLEN-1:0] w_x;
    logic [XLEN-1:0] w_y;
    logic [SW-1:0]   w_shamt;

    assign w_shamt = w_y[SW-1:0];

`ifdef ALU_SERIAL_SHIFT_EN
    assign o_x     = w_x;
    assign o_shamt = w_shamt;
`endif

    always_comb begin
        w_x = '0;
        case (i_sel_x)
            AM_RS1:  w_x = i_rs1;
            AM_RS2:  w_x = i_rs2;
            AM_IMM:  w_x = i_imm;
            AM_PC:   w_x = i_pc;
            default: w_x = '0;
        endcase
    end

    always_comb begin
        w_y = '0;
        case (i_sel_y)
            AM_RS1:  w_y = i_rs1;
            AM_RS2:  w_y = i_rs2;
            AM_IMM:  w_y = i_imm;
            AM_PC:   w_y = i_pc;
            default: w_y = '0;
        endcase
    end

    always_comb begin
        o_result = '0;
        case (i_op)
            A_ADD:   o_result = w_x + w_y;
            A_SUB:   o_result = w_x - w_y;
            A_AND:   o_result = w_x & w_y;
            A_OR:    o_result = w_x | w_y;
            A_XOR:   o_result = w_x ^ w_y;
            A_SLL:   o_result = w_x << w_shamt;
            A_SRL:   o_result = w_x >> w_shamt;
            A_SRA:   o_result = $signed(w_x) >>> w_shamt;
            A_SLT:   o_result = {{(XLEN-1){1'b0}}, $signed(w_x) < $signed(w_y)};
            A_SLTU:  o_result = {{(XLEN-1){1'b0}}, w_x < w_y};
            A_MIN:   o_result = ($signed(w_x) < $signed(w_y)) ? w_x : w_y;
            A_MAX:   o_result = ($signed(w_x) < $signed(w_y)) ? w_y : w_x;
            A_MINU:  o_result = (w_x < w_y) ? w_x : w_y;
            A_MAXU:  o_result = (w_x < w_y) ? w_y : w_x;
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/alu_fu_pipe.sv
// LAT-deep elastic ALU pipeline with valid/ready handshakes, per-op tag and flush.
// Define ALU_SERIAL_SHIFT_EN for a 1-bit/cycle shifter instead of the barrel shifter.
module alu_fu_pipe
    import alu_fu_pipe_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned LAT   = 2,
    parameter int unsigned TAG_W = 4
) (
    input  logic                       clk_in,
    input  logic                       reset_in,
    input  logic                       flush_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            rs1_data,
    input  logic [XLEN-1:0]            rs2_data,
    input  logic [XLEN-1:0]            imm,
    input  logic [XLEN-1:0]            pc,
    input  ALU_SEL_TYPE                sel_x,
    input  ALU_SEL_TYPE                sel_y,
    input  ALU_OP_TYPE                 op,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            rd_data,
    output logic [TAG_W-1:0]           out_tag,
    output logic [$clog2(LAT+1)-1:0]   occupancy
);

    localparam int unsigned OCC_W = $clog2(LAT + 1);

    // Declared here rather than in the package so field widths follow XLEN/TAG_W.
    typedef struct packed {
        logic             valid;
        logic [XLEN-1:0]  data;
        logic [TAG_W-1:0] tag;
    } ALU_STAGE_T;

    ALU_STAGE_T       r_stage [LAT];
    ALU_STAGE_T       w_in;
    logic [LAT-1:0]   w_open;
    logic [XLEN-1:0]  w_res;
    logic             w_idle;
    logic             w_accept;

    // A stage can take new content when empty or when its content moves on.
    always_comb begin
        w_open          = '0;
        w_open[LAT-1]   = !r_stage[LAT-1].valid || out_ready;
        for (int unsigned k = LAT - 1; k > 0; k--) begin
            w_open[k-1] = !r_stage[k-1].valid || w_open[k];
        end
    end

    assign in_ready  = w_open[0] && w_idle && !flush_in;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_stage[LAT-1].valid;
    assign rd_data   = r_stage[LAT-1].data;
    assign out_tag   = r_stage[LAT-1].tag;

`ifdef ALU_SERIAL_SHIFT_EN
    localparam int unsigned SW = $clog2(XLEN);

    typedef enum logic {
        SH_IDLE,
        SH_SHIFT
    } SH_STATE_T;

    SH_STATE_T        r_state;
    SH_STATE_T        w_state_nx;
    logic [XLEN-1:0]  r_sh;
    logic [XLEN-1:0]  w_sh_step;
    logic [SW-1:0]    r_cnt;
    ALU_OP_TYPE       r_op;
    logic [TAG_W-1:0] r_tag;
    logic [XLEN-1:0]  w_x;
    logic [SW-1:0]    w_shamt;
    logic             w_start;
    logic             w_fin;

    alu_fu_core #(.XLEN(XLEN)) u_core (
        .i_rs1    (rs1_data),
        .i_rs2    (rs2_data),
        .i_imm    (imm),
        .i_pc     (pc),
        .i_sel_x  (sel_x),
        .i_sel_y  (sel_y),
        .i_op     (op),
        .o_result (w_res),
        .o_x      (w_x),
        .o_shamt  (w_shamt)
    );

    assign w_idle  = (r_state == SH_IDLE);
    assign w_start = w_accept && is_shift_op(op) && (w_shamt != '0);
    // The final shift step lands in stage 1 on the same edge; a stalled result waits in r_sh.
    assign w_fin   = (r_state == SH_SHIFT) && (r_cnt <= SW'(1));

    always_comb begin
        w_sh_step = {r_sh[XLEN-1], r_sh[XLEN-1:1]};
        case (r_op)
            A_SLL:   w_sh_step = r_sh << 1;
            A_SRL:   w_sh_step = r_sh >> 1;
            default: w_sh_step = {r_sh[XLEN-1], r_sh[XLEN-1:1]};
        endcase
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            SH_IDLE:  if (w_start) w_state_nx = SH_SHIFT;
            SH_SHIFT: if (w_fin && w_open[0]) w_state_nx = SH_IDLE;
            default:  w_state_nx = SH_IDLE;
        endcase
        if (flush_in) w_state_nx = SH_IDLE;
    end

    always_comb begin
        w_in = '0;
        if (r_state == SH_SHIFT) begin
            w_in.valid = w_fin;
            w_in.data  = (r_cnt == '0) ? r_sh : w_sh_step;
            w_in.tag   = r_tag;
        end else begin
            w_in.valid = w_accept && !w_start;
            w_in.data  = w_res;
            w_in.tag   = in_tag;
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_state <= SH_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_sh  <= '0;
            r_cnt <= '0;
            r_op  <= A_SLL;
            r_tag <= '0;
        end else if (w_start) begin
            r_sh  <= w_x;
            r_cnt <= w_shamt;
            r_op  <= op;
            r_tag <= in_tag;
        end else if ((r_state == SH_SHIFT) && (r_cnt != '0)) begin
            r_sh  <= w_sh_step;
            r_cnt <= r_cnt - SW'(1);
        end
    end
`else
    alu_fu_core #(.XLEN(XLEN)) u_core (
        .i_rs1    (rs1_data),
        .i_rs2    (rs2_data),
        .i_imm    (imm),
        .i_pc     (pc),
        .i_sel_x  (sel_x),
        .i_sel_y  (sel_y),
        .i_op     (op),
        .o_result (w_res)
    );

    assign w_idle = 1'b1;

    always_comb begin
        w_in       = '0;
        w_in.valid = w_accept;
        w_in.data  = w_res;
        w_in.tag   = in_tag;
    end
`endif

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            for (int unsigned k = 0; k < LAT; k++) begin
                r_stage[k] <= '0;
            end
        end else if (flush_in) begin
            for (int unsigned k = 0; k < LAT; k++) begin
                r_stage[k].valid <= 1'b0;
            end
        end else begin
            if (w_open[0]) r_stage[0] <= w_in;
            for (int unsigned k = 1; k < LAT; k++) begin
                if (w_open[k]) r_stage[k] <= r_stage[k-1];
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int unsigned k = 0; k < LAT; k++) begin
            if (r_stage[k].valid) occupancy = occupancy + OCC_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_fu_pipe.sv
// Self-checking bench for alu_fu_pipe: scoreboard queue of {data, tag} filled on
// accept and drained by an output monitor, plus per-scenario inline checks.
module tb_alu_fu_pipe;
    import alu_fu_pipe_pkg::*;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned LAT   = 2;
    localparam int unsigned TAG_W = 4;
    localparam int unsigned OCC_W = $clog2(LAT + 1);

    logic              clk_in    = 1'b0;
    logic              reset_in  = 1'b0;
    logic              flush_in  = 1'b0;
    logic              in_valid  = 1'b0;
    logic              in_ready;
    logic [XLEN-1:0]   rs1_data  = '0;
    logic [XLEN-1:0]   rs2_data  = '0;
    logic [XLEN-1:0]   imm       = '0;
    logic [XLEN-1:0]   pc        = '0;
    ALU_SEL_TYPE       sel_x     = AM_RS1;
    ALU_SEL_TYPE       sel_y     = AM_RS2;
    ALU_OP_TYPE        op        = A_ADD;
    logic [TAG_W-1:0]  in_tag    = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [XLEN-1:0]   rd_data;
    logic [TAG_W-1:0]  out_tag;
    logic [OCC_W-1:0]  occupancy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [XLEN+TAG_W-1:0] exp_q [$];

    alu_fu_pipe #(.XLEN(XLEN), .LAT(LAT), .TAG_W(TAG_W)) dut (
        .clk_in    (clk_in),
        .reset_in  (reset_in),
        .flush_in  (flush_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .imm       (imm),
        .pc        (pc),
        .sel_x     (sel_x),
        .sel_y     (sel_y),
        .op        (op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rd_data   (rd_data),
        .out_tag   (out_tag),
        .occupancy (occupancy)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required earlier", $time);
        $fatal(1, "watchdog");
    end

    // Output monitor: every output handshake must match the oldest accepted op.
    always @(negedge clk_in) begin
        if (reset_in && out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_unexpected: got data=%h tag=%0d, required no output", rd_data, out_tag);
            end else begin
                logic [XLEN+TAG_W-1:0] e;
                e = exp_q.pop_front();
                if ({rd_data, out_tag} !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard_result: got data=%h tag=%0d, required data=%h tag=%0d",
                             rd_data, out_tag, e[XLEN+TAG_W-1:TAG_W], e[TAG_W-1:0]);
                end
            end
        end
    end

    function automatic logic [XLEN-1:0] pick(input ALU_SEL_TYPE s, input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b, input logic [XLEN-1:0] im,
                                             input logic [XLEN-1:0] p);
        case (s)
            AM_RS1:  return a;
            AM_RS2:  return b;
            AM_IMM:  return im;
            default: return p;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] model(input ALU_OP_TYPE o, input logic [XLEN-1:0] x,
                                              input logic [XLEN-1:0] y);
        int unsigned sh;
        logic signed [XLEN-1:0] sx;
        logic signed [XLEN-1:0] sy;
        sh = int'(y % XLEN);
        sx = x;
        sy = y;
        case (o)
            A_ADD:   return x + y;
            A_SUB:   return x - y;
            A_AND:   return x & y;
            A_OR:    return x | y;
            A_XOR:   return x ^ y;
            A_SLL:   return x << sh;
            A_SRL:   return x >> sh;
            A_SRA:   return sx >>> sh;
            A_SLT:   return (sx < sy) ? 1 : 0;
            A_SLTU:  return (x < y) ? 1 : 0;
            A_MIN:   return (sx < sy) ? x : y;
            A_MAX:   return (sx > sy) ? x : y;
            A_MINU:  return (x < y) ? x : y;
            A_MAXU:  return (x > y) ? x : y;
            default: return '0;
        endcase
    endfunction

    // Presents one op until accepted (bounded) and records its expected result.
    task automatic send(input ALU_OP_TYPE o, input ALU_SEL_TYPE sx, input ALU_SEL_TYPE sy,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] im, input logic [XLEN-1:0] p,
                        input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] expv);
        int n = 0;
        op = o; sel_x = sx; sel_y = sy;
        rs1_data = a; rs2_data = b; imm = im; pc = p;
        in_tag = tag; in_valid = 1'b1;
        @(negedge clk_in);
        while (in_ready !== 1'b1 && n < 200) begin
            @(posedge clk_in); #1;
            @(negedge clk_in);
            n++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_timeout: in_ready=%b required 1 for tag %0d", in_ready, tag);
        end else begin
            exp_q.push_back({expv, tag});
        end
        @(posedge clk_in); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        int lat = 0;
        reset_in = 1'b0; out_ready = 1'b1;
        op = A_ADD; rs1_data = 32'h1234; rs2_data = 32'h1; in_tag = 4'hA; in_valid = 1'b1;
        repeat (3) @(negedge clk_in);
        n_checks++;
        if (out_valid !== 1'b0 || occupancy !== '0 || rd_data !== '0 || out_tag !== '0) begin
            n_fail++;
            $display("FAIL reset_state: out_valid=%b occ=%0d rd=%h tag=%0d, required 0 0 0 0",
                     out_valid, occupancy, rd_data, out_tag);
        end
        @(posedge clk_in); #1;
        in_valid = 1'b0; reset_in = 1'b1;
        @(negedge clk_in);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
        repeat (LAT) @(negedge clk_in);
        n_checks++;
        if (out_valid !== 1'b0 || occupancy !== '0) begin
            n_fail++;
            $display("FAIL reset_no_capture: out_valid=%b occ=%0d, required 0 0", out_valid, occupancy);
        end
        @(posedge clk_in); #1;
        send(A_ADD, AM_RS1, AM_RS2, 32'hFFFF_FFFF, 32'h1, '0, '0, 4'd3, 32'h0);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk_in);
            if (out_valid === 1'b1) begin lat = k; break; end
        end
        n_checks++;
        if (lat != LAT || rd_data !== 32'h0 || out_tag !== 4'd3) begin
            n_fail++;
            $display("FAIL first_latency: lat=%0d rd=%h tag=%0d, required lat=%0d rd=0 tag=3",
                     lat, rd_data, out_tag, LAT);
        end
        @(posedge clk_in); #1;
    endtask

    task automatic test_back_to_back;
        time t0;
        time t1;
        out_ready = 1'b1;
        t0 = $time;
        send(A_SUB,  AM_RS1, AM_RS2, 32'd5,         32'd7,  '0, '0, 4'd1, 32'hFFFF_FFFE);
        send(A_SLT,  AM_RS1, AM_RS2, 32'hFFFF_FFFF, 32'd1,  '0, '0, 4'd2, 32'h1);
        send(A_SLTU, AM_RS1, AM_RS2, 32'hFFFF_FFFF, 32'd1,  '0, '0, 4'd3, 32'h0);
        send(A_MIN,  AM_RS1, AM_RS2, 32'hFFFF_FFFC, 32'd3,  '0, '0, 4'd4, 32'hFFFF_FFFC);
        send(A_MAXU, AM_RS1, AM_RS2, 32'h8000_0000, 32'd1,  '0, '0, 4'd5, 32'h8000_0000);
        t1 = $time;
        n_checks++;
        if (t1 - t0 != 50) begin
            n_fail++;
            $display("FAIL b2b_throughput: 5 accepts took %0t, required 50", t1 - t0);
        end
        repeat (LAT) @(negedge clk_in);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_drain: %0d results pending, required 0", exp_q.size());
        end
        @(posedge clk_in); #1;
    endtask

    task automatic test_operand_sel;
        out_ready = 1'b1;
        send(A_ADD, AM_PC,  AM_IMM, '0, '0, 32'h2000, 32'h1000, 4'd6, 32'h3000);
        send(A_SRA, AM_RS1, AM_IMM, 32'h8000_0000, '0, 32'd31, '0, 4'd7, 32'hFFFF_FFFF);
        send(A_SUB, AM_IMM, AM_RS2, 32'd0, 32'd10, 32'd3, '0, 4'd8, 32'hFFFF_FFF9);
        send(A_XOR, AM_RS2, AM_PC,  '0, 32'hF0F0_0000, '0, 32'h0F0F_00FF, 4'd9, 32'hFFFF_00FF);
        send(A_MAX, AM_RS1, AM_RS2, 32'hFFFF_FFFB, 32'hFFFF_FFF7, '0, '0, 4'd10, 32'hFFFF_FFFB);
        send(A_MINU, AM_RS1, AM_RS2, 32'd7, 32'hFFFF_FFFF, '0, '0, 4'd11, 32'd7);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk_in);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL opsel_drain: %0d results pending, required 0", exp_q.size());
        end
        @(posedge clk_in); #1;
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        fork
            begin
                send(A_ADD, AM_RS1, AM_RS2, 32'd10, 32'd20, '0, '0, 4'd1, 32'd30);
                send(A_OR,  AM_RS1, AM_RS2, 32'hF0, 32'h0F, '0, '0, 4'd2, 32'hFF);
                send(A_AND, AM_RS1, AM_RS2, 32'hFF00, 32'h0FF0, '0, '0, 4'd3, 32'h0F00);
                send(A_SLTU, AM_RS1, AM_RS2, 32'd1, 32'hFFFF_FFFF, '0, '0, 4'd4, 32'd1);
            end
            begin
                repeat (3) @(negedge clk_in);
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk_in);
                    n_checks++;
                    if (occupancy !== OCC_W'(LAT) || in_ready !== 1'b0 || out_valid !== 1'b1 ||
                        rd_data !== 32'd30 || out_tag !== 4'd1) begin
                        n_fail++;
                        $display("FAIL backpressure_hold: occ=%0d in_ready=%b out_valid=%b rd=%h tag=%0d, required %0d 0 1 1e 1",
                                 occupancy, in_ready, out_valid, rd_data, out_tag, LAT);
                    end
                end
                @(posedge clk_in); #1;
                out_ready = 1'b1;
            end
        join
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk_in);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL backpressure_drain: %0d results pending, required 0", exp_q.size());
        end
        @(posedge clk_in); #1;
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        send(A_ADD, AM_RS1, AM_RS2, 32'd1, 32'd2, '0, '0, 4'd8, 32'd3);
        send(A_ADD, AM_RS1, AM_RS2, 32'd4, 32'd5, '0, '0, 4'd9, 32'd9);
        flush_in = 1'b1;
        op = A_ADD; rs1_data = 32'd7; rs2_data = 32'd7; in_tag = 4'd10; in_valid = 1'b1;
        @(negedge clk_in);
        n_checks++;
        if (in_ready !== 1'b0 || occupancy !== OCC_W'(2)) begin
            n_fail++;
            $display("FAIL flush_cycle: in_ready=%b occ=%0d, required 0 2", in_ready, occupancy);
        end
        @(posedge clk_in); #1;
        flush_in = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk_in);
        n_checks++;
        if (out_valid !== 1'b0 || occupancy !== '0) begin
            n_fail++;
            $display("FAIL flush_cleared: out_valid=%b occ=%0d, required 0 0", out_valid, occupancy);
        end
        @(posedge clk_in); #1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk_in);
        @(posedge clk_in); #1;
        send(A_SUB, AM_RS1, AM_RS2, 32'd100, 32'd1, '0, '0, 4'd11, 32'd99);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk_in);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL flush_after: %0d results pending, required 0", exp_q.size());
        end
        @(posedge clk_in); #1;
    endtask

    task automatic test_shift_latency;
        int exp_lat;
        int exp_low;
        int lat;
        int low;
`ifdef ALU_SERIAL_SHIFT_EN
        exp_lat = 31 + LAT;
        exp_low = 31;
`else
        exp_lat = LAT;
        exp_low = 0;
`endif
        out_ready = 1'b1;
        lat = 0; low = 0;
        send(A_SLL, AM_RS1, AM_RS2, 32'd1, 32'd31, '0, '0, 4'd5, 32'h8000_0000);
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk_in);
            if (in_ready !== 1'b1) low++;
            if (out_valid === 1'b1) begin lat = k; break; end
        end
        n_checks++;
        if (lat != exp_lat || low != exp_low || rd_data !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL shift31_latency: lat=%0d busy=%0d rd=%h, required lat=%0d busy=%0d rd=80000000",
                     lat, low, rd_data, exp_lat, exp_low);
        end
        @(posedge clk_in); #1;
        lat = 0;
        send(A_SRL, AM_RS1, AM_IMM, 32'hDEAD_BEEF, '0, 32'd32, '0, 4'd6, 32'hDEAD_BEEF);
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk_in);
            if (out_valid === 1'b1) begin lat = k; break; end
        end
        n_checks++;
        if (lat != LAT || rd_data !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL shift0_latency: lat=%0d rd=%h, required lat=%0d rd=deadbeef", lat, rd_data, LAT);
        end
        @(posedge clk_in); #1;
    endtask

    task automatic test_random;
        bit done;
        ALU_OP_TYPE o;
        ALU_SEL_TYPE sx;
        ALU_SEL_TYPE sy;
        logic [XLEN-1:0] a, b, im, p;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    o  = ALU_OP_TYPE'(4'($urandom_range(0, 13)));
                    sx = ALU_SEL_TYPE'(2'($urandom_range(0, 3)));
                    sy = ALU_SEL_TYPE'(2'($urandom_range(0, 3)));
                    a  = $urandom;
                    b  = ($urandom_range(0, 2) == 0) ? XLEN'($urandom_range(0, 40)) : XLEN'($urandom);
                    im = XLEN'($urandom_range(0, 63));
                    p  = $urandom;
                    send(o, sx, sy, a, b, im, p, TAG_W'(i),
                         model(o, pick(sx, a, b, im, p), pick(sy, a, b, im, p)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk_in); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        @(posedge clk_in); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge clk_in);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL random_drain: %0d results pending, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_operand_sel();
        test_backpressure();
        test_flush();
        test_shift_latency();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_fu_pipe.md
Name: alu_fu_pipe

Overview:
- Parametrised successor to the single-cycle ALU functional unit.
- Operand-select muxes and ALU ops as before, generalised to XLEN-bit data.
- Adds signed/unsigned MIN/MAX ops, a LAT-deep elastic result pipeline with valid/ready backpressure, a tag carried per op, and flush.
- Sits in the EXE stage beside the other FUs; EXE consumes rd_data/out_tag when out_valid.

Parameters:
- XLEN, 32, data/operand width; shift amount uses the low $clog2(XLEN) bits of y.
- LAT, 2, result register stages, 1..4; zero-stall latency from accept to out_valid is LAT cycles.
- TAG_W, 4, width of the opaque tag carried with each op.

Ports:
- clk_in  in  1  clock.
- reset_in  in  1  asynchronous, active-low reset.
- flush_in  in  1  synchronous kill of all in-flight ops.
- in_valid  in  1  op presented.
- in_ready  out  1  unit can accept this cycle.
- rs1_data  in  XLEN  source operand 1.
- rs2_data  in  XLEN  source operand 2.
- imm  in  XLEN  immediate.
- pc  in  XLEN  instruction PC.
- sel_x  in  ALU_SEL_TYPE  x mux select: AM_RS1/AM_RS2/AM_IMM/AM_PC.
- sel_y  in  ALU_SEL_TYPE  y mux select, same encoding.
- op  in  ALU_OP_TYPE  ALU operation.
- in_tag  in  TAG_W  tag accompanying the op.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- rd_data  out  XLEN  result.
- out_tag  out  TAG_W  tag of the result.
- occupancy  out  $clog2(LAT+1)  number of valid stages.

Behaviour:
- Reset (reset_in=0, async): all stage valids=0; out_valid=0; rd_data=0; out_tag=0; occupancy=0; shift FSM=IDLE.
- Accept: an op is accepted when in_valid && in_ready.
- Compute: mux_x/mux_y and the op result are combinational, then written into stage 1.
- Ops:
  - AND, OR, XOR, ADD, SUB wrap modulo 2^XLEN.
  - SLL/SRL/SRA use shamt = mux_y[$clog2(XLEN)-1:0].
  - SLT/SLTU write 1/0 zero-extended.
  - MIN/MAX compare signed; MINU/MAXU compare unsigned.
- Pipeline: stage k advances into k+1 when k+1 is empty or advancing. The last stage is output (rd_data/out_tag hold while out_valid && !out_ready).
- in_ready = stage 1 empty or advancing, and shift FSM IDLE. This is a combinational path from out_ready.
- Full pipeline with out_ready=0: in_ready=0; no data is lost or overwritten.
- Simultaneous: out handshake and in handshake in the same cycle when full gives full throughput, 1 op/cycle.
- Order: results leave in acceptance order.
- flush_in=1:
  - Next edge clears all valids and the shift FSM.
  - in_ready=0 that cycle; any in_valid presented is ignored.
  - A flush coinciding with out handshake still counts as consumed.
- occupancy = count of valid stages, updated each edge.

Optional Feature:
- Macro: ALU_SERIAL_SHIFT_EN.
- When defined:
  - SLL/SRL/SRA use a 1-bit/cycle shifter, FSM states IDLE → SHIFT.
  - Accepting a shift with shamt>0 loads the shift register and counter=shamt and enters SHIFT; in_ready=0.
  - Each cycle shifts 1 bit and decrements the counter. When the counter reaches 0, the result is written to stage 1 when it can advance, and the FSM returns to IDLE.
  - shamt=0 takes the single-cycle path.
  - Shift latency = shamt+LAT.
- When not defined: barrel shifter; all ops have LAT latency.

Decomposition:
- cpu_params_pkg / cpu_structs_pkg:
  - extend ALU_OP_TYPE with A_MIN, A_MAX, A_MINU, A_MAXU.
  - ALU_SEL_TYPE unchanged.
  - add ALU_STAGE_T struct {valid, data, tag}.
- One sub-module: alu_fu_core, the combinational mux + op evaluator parametrised by XLEN, reused by the serial-shift path for non-shift ops.

Test Plan:
- Reset with in_valid=1 → out_valid=0, in_ready=1 after release. Then ADD rs1=0xFFFFFFFF, rs2=1 (RS1/RS2), tag 3 → after 2 cycles rd_data=0, out_tag=3.
- Back-to-back: SUB 5-7, SLT -1<1, SLTU 0xFFFFFFFF<1, MIN -4/3, MAXU 0x80000000/1 each cycle, out_ready=1 → results 0xFFFFFFFE, 1, 0, 0xFFFFFFFC, 0x80000000 in order, one per cycle.
- Backpressure: out_ready=0 for 5 cycles while streaming → occupancy saturates at 2, in_ready=0, rd_data stable. Release → no loss or duplication.
- Flush with 2 ops in flight plus in_valid → next cycle out_valid=0, occupancy=0; the flushed tags never appear.
- AUIPC-style: sel_x=AM_PC pc=0x1000, sel_y=AM_IMM imm=0x2000, ADD → 0x3000. SRA 0x80000000 by 31 → 0xFFFFFFFF.
- With ALU_SERIAL_SHIFT_EN: SLL 1 by 31 → in_ready low 31 cycles, rd_data=0x80000000 at cycle 31+LAT. A shift with shamt=0 takes LAT cycles.
